// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/sub, STAGES registered carry segments, valid/ready handshake.
// Define PIPELINED_ADDER_FLAGS_EN to build the overflow/zero/negative flag logic.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CI,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             CO,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int unsigned C = (STAGES == 0) ? WIDTH : WIDTH / STAGES;
  localparam int unsigned L = (STAGES == 0) ? 0 : STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: STAGES must be in 1..WIDTH and divide WIDTH");
  end

  logic adv;

  // Stage k keeps only the operand bits still to be added and the sum bits already
  // produced, so register widths shrink/grow along the pipe instead of carrying dead bits.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IW = WIDTH - k * C;

    logic [IW-1:0]        a_rem;
    logic [IW-1:0]        bv_rem;
    logic                 c_in;
    logic                 v_in;
    logic [C:0]           seg;
    logic [(k+1)*C-1:0]   s_nxt;
    logic [(k+1)*C-1:0]   s_q;
    logic                 c_q;
    logic                 v_q;

    if (k == 0) begin : g_entry
      assign a_rem  = A;
      assign bv_rem = sub ? ~B : B;
      assign c_in   = sub | CI;
      assign v_in   = in_valid;
      assign s_nxt  = seg[C-1:0];
    end else begin : g_link
      assign a_rem  = g_stage[k-1].g_fwd.a_q;
      assign bv_rem = g_stage[k-1].g_fwd.bv_q;
      assign c_in   = g_stage[k-1].c_q;
      assign v_in   = g_stage[k-1].v_q;
      assign s_nxt  = {seg[C-1:0], g_stage[k-1].s_q};
    end

    assign seg = {1'b0, a_rem[C-1:0]} + {1'b0, bv_rem[C-1:0]} + {{C{1'b0}}, c_in};

    // Data only loads with a real operation so bubbles never disturb the held result.
    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (adv) begin
        v_q <= v_in;
        if (v_in) begin
          s_q <= s_nxt;
          c_q <= seg[C];
        end
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [IW-C-1:0] a_q;
      logic [IW-C-1:0] bv_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q  <= '0;
          bv_q <= '0;
        end else if (adv && v_in) begin
          a_q  <= a_rem[IW-1:C];
          bv_q <= bv_rem[IW-1:C];
        end
      end
    end
  end

  assign out_valid = g_stage[L].v_q;
  assign out       = g_stage[L].s_q;
  assign CO        = g_stage[L].c_q;
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !reset;

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic             ovf_q;
  logic             zero_q;
  logic             neg_q;
  logic             cmsb;
  logic [WIDTH-1:0] last_sum;

  assign last_sum = g_stage[L].s_nxt;
  assign cmsb     = g_stage[L].a_rem[C-1] ^ g_stage[L].bv_rem[C-1] ^ g_stage[L].seg[C-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (adv && g_stage[L].v_in) begin
      ovf_q  <= cmsb ^ g_stage[L].seg[C];
      zero_q <= (last_sum == '0);
      neg_q  <= last_sum[WIDTH-1];
    end
  end

  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign negative = neg_q;
`else
  assign overflow = 1'b0;
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: table vectors, random streaming with backpressure
// against a plain-arithmetic model, reset corners on a 4-stage and a 1-stage instance.
module tb_pipelined_adder;

  localparam int unsigned W  = 64;
  localparam int unsigned S4 = 4;
`ifdef PIPELINED_ADDER_FLAGS_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, in_valid, in_ready, CI, sub, out_valid, out_ready, CO, overflow, zero, negative;
  logic [W-1:0] A, B, out;

  logic         reset1, in_valid1, in_ready1, ci1, sub1, out_valid1, out_ready1, co1, ov1, z1, n1;
  logic [W-1:0] a1, b1, out1;

  pipelined_adder #(.WIDTH(W), .STAGES(S4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .CI(CI), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .CO(CO), .overflow(overflow), .zero(zero), .negative(negative)
  );

  pipelined_adder #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset1), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .CI(ci1), .sub(sub1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out(out1), .CO(co1), .overflow(ov1), .zero(z1), .negative(n1)
  );

  typedef struct {
    logic [W-1:0] o;
    logic         co, ov, z, n;
    int           acc;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         ci, s;
    logic [W-1:0] o;
    logic         co, ov, z, n;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   nres = 0;
  bit   strict = 1'b1;
  bit   last_in_fire;
  logic [W-1:0] last_out;
  exp_t q[$];
  vec_t tbl[8];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic s);
    exp_t e;
    logic [W:0] full;
    if (s) begin
      e.o  = a - b;
      e.co = (a >= b);
      e.ov = (a[W-1] != b[W-1]) && (e.o[W-1] != a[W-1]);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
      e.o  = full[W-1:0];
      e.co = full[W];
      e.ov = (a[W-1] == b[W-1]) && (e.o[W-1] != a[W-1]);
    end
    e.z   = FE & (e.o == '0);
    e.n   = FE & e.o[W-1];
    e.ov  = FE & e.ov;
    e.acc = 0;
    return e;
  endfunction

  // One clock: observe transfers before the edge, score them, then settle past the edge.
  task automatic step();
    bit           inf, outf, stall, rst_s;
    logic [W-1:0] held;
    exp_t         e;
    #1;
    rst_s = reset;
    inf   = in_valid && in_ready;
    outf  = out_valid && out_ready && !reset;
    stall = out_valid && !out_ready && !reset;
    held  = out;
    if (!reset) chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
    if (outf) begin
      if (q.size() == 0) begin
        chk("unexpected_result", out, 'x);
      end else begin
        e = q.pop_front();
        chk("res_out", out, e.o);
        chk("res_co", CO, e.co);
        chk("res_ovf", overflow, e.ov);
        chk("res_zero", zero, e.z);
        chk("res_neg", negative, e.n);
        if (strict) chk("latency", cyc + 1 - e.acc, S4);
        last_out = out;
        nres++;
      end
    end
    if (inf) begin
      e = model(A, B, CI, sub);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    last_in_fire = inf;
    @(posedge clk);
    cyc++;
    #1;
    if (rst_s) q.delete();
    if (stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_hold", out, held);
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() > 0 || out_valid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", q.size(), 0);
  endtask

  task automatic rand_ops();
    A   = {$urandom, $urandom};
    B   = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) A = '1;
    if ($urandom_range(0, 7) == 0) B = '0;
    CI  = $urandom_range(0, 1);
    sub = $urandom_range(0, 1);
  endtask

  task automatic run_one(input vec_t v);
    int n = 0;
    A = v.a; B = v.b; CI = v.ci; sub = v.s;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    chk("tbl_accept", last_in_fire, 1);
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk("tbl_latency", n, S4 - 1);
    chk("tbl_out", out, v.o);
    chk("tbl_co", CO, v.co);
    chk("tbl_ovf", overflow, v.ov & FE);
    chk("tbl_zero", zero, v.z & FE);
    chk("tbl_neg", negative, v.n & FE);
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //             a                        b                        ci    s     o                        co    ov    z     n
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b1, 1'b0, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                   1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{64'h5,                   64'h7,                   1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{64'h7,                   64'h5,                   1'b0, 1'b1, 64'h2,                   1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'h1,                   1'b0, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{64'h0,                   64'h0,                   1'b0, 1'b1, 64'h0,                   1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{64'h1,                   64'h2,                   1'b0, 1'b0, 64'h3,                   1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{64'hA,                   64'h3,                   1'b1, 1'b1, 64'h7,                   1'b1, 1'b0, 1'b0, 1'b0};

    reset1 = 1'b1; in_valid1 = 1'b0; out_ready1 = 1'b1;
    a1 = '0; b1 = '0; ci1 = 1'b0; sub1 = 1'b0;

    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    rand_ops();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out", out, 0);
      chk("rst_co", CO, 0);
      chk("rst_flags", {overflow, zero, negative}, 0);
    end
    reset = 1'b0;
    A = 64'h10; B = 64'h20; CI = 1'b0; sub = 1'b0;
    step();
    chk("first_accept", last_in_fire, 1);
    drain(20);

    foreach (tbl[i]) run_one(tbl[i]);

    nres = 0;
    for (int i = 0; i < 100; i++) begin
      rand_ops();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
    end
    drain(20);
    chk("stream_count", nres, 100);

    nres = 0;
    strict = 1'b0;
    begin
      int  sent = 0;
      int  g = 0;
      bit  fresh = 1'b1;
      while (sent < 10 && g < 300) begin
        if (fresh) rand_ops();
        in_valid  = 1'b1;
        out_ready = $urandom_range(0, 1);
        step();
        fresh = last_in_fire;
        if (last_in_fire) sent++;
        g++;
      end
      chk("bp_sent", sent, 10);
    end
    drain(40);
    chk("bp_count", nres, 10);
    strict = 1'b1;

    nres = 0;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      step();
    end
    chk("mid_no_result", out_valid, 0);
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    A = 64'h1; B = 64'h2; CI = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    step();
    drain(20);
    chk("mid_count", nres, 1);
    chk("mid_result", last_out, 3);

    // Single-stage instance: one-cycle latency, stall, reset drop, flags.
    step();
    chk("s1_rst_valid", out_valid1, 0);
    chk("s1_rst_out", out1, 0);
    reset1 = 1'b0;
    a1 = 64'd5; b1 = 64'd9; in_valid1 = 1'b1; out_ready1 = 1'b0;
    #1;
    chk("s1_in_ready", in_ready1, 1);
    step();
    in_valid1 = 1'b0;
    chk("s1_latency", out_valid1, 1);
    chk("s1_out", out1, 14);
    step();
    chk("s1_hold", out1, 14);
    chk("s1_stall_ready", in_ready1, 0);
    reset1 = 1'b1;
    step();
    chk("s1_dropped", out_valid1, 0);
    reset1 = 1'b0;
    a1 = 64'd1; b1 = 64'd2; in_valid1 = 1'b1; out_ready1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("s1_res_valid", out_valid1, 1);
    chk("s1_res_out", out1, 3);
    chk("s1_res_flags", {ov1, z1, n1}, 0);
    step();
    chk("s1_no_stale", out_valid1, 0);
    a1 = 64'h7FFF_FFFF_FFFF_FFFF; b1 = 64'd1; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    chk("s1_ovf_out", out1, 64'h8000_0000_0000_0000);
    chk("s1_ovf", ov1, FE);
    chk("s1_neg", n1, FE);
    chk("s1_co", co1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
